// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control sequencer: walks fetch/decode/execute/memory/writeback,
// drives datapath selects, counts retired instructions and flags illegal opcodes or memory timeouts.
module legv8_multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [10:0]            opcode,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_source,
    output logic                   ir_write,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   reg2loc,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   illegal,
    output logic                   mem_fault
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        HALT      = 4'd10
    } state_t;

    state_t              cur;
    state_t              nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                is_ldur, is_stur, is_rtype, is_cbz, is_b;
    logic                waiting, timeout, decode_bad, retire;

    assign state = cur;

    assign is_ldur  = (opcode == 11'b11111000010);
    assign is_stur  = (opcode == 11'b11111000000);
    assign is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                      (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
    assign is_cbz   = (opcode[10:3] == 8'b10110100);
    assign is_b     = (opcode[10:5] == 6'b000101);

    // Only the three memory-handshake states count toward the timeout.
    assign waiting    = (cur == FETCH) || (cur == MEM_READ) || (cur == MEM_WRITE);
    assign timeout    = waiting && !mem_ready && (wait_cnt == WAIT_LAST);
    assign decode_bad = (cur == DECODE) && !(is_ldur || is_stur || is_rtype || is_cbz || is_b);
    assign retire     = (nxt == FETCH) &&
                        (cur == MEM_WB || cur == MEM_WRITE || cur == R_WB || cur == BRANCH || cur == JUMP);

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:     if (mem_ready) nxt = DECODE;
            DECODE: begin
                if (is_ldur || is_stur) nxt = MEM_ADDR;
                else if (is_rtype)      nxt = EXECUTE;
                else if (is_cbz)        nxt = BRANCH;
                else if (is_b)          nxt = JUMP;
                else                    nxt = HALT;
            end
            MEM_ADDR:  nxt = is_ldur ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) nxt = MEM_WB;
            MEM_WB:    nxt = FETCH;
            MEM_WRITE: if (mem_ready) nxt = FETCH;
            EXECUTE:   nxt = R_WB;
            R_WB:      nxt = FETCH;
            BRANCH:    nxt = FETCH;
            JUMP:      nxt = FETCH;
            HALT:      nxt = HALT;
            default:   nxt = FETCH;
        endcase
        if (timeout) nxt = HALT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
            mem_fault   <= 1'b0;
        end else begin
            cur <= nxt;
            // Any state change restarts the wait; staying in a wait state means mem_ready was low.
            if (waiting && nxt == cur) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                       wait_cnt <= '0;
            if (retire)     instr_count <= instr_count + COUNT_WIDTH'(1);
            if (decode_bad) illegal     <= 1'b1;
            if (timeout)    mem_fault   <= 1'b1;
        end
    end

    // Mealy decode of the datapath controls; everything is held low while reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg2loc    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE:    alu_src_b = 2'b11;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    reg2loc   = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB:      reg_write = 1'b1;
                BRANCH: begin
                    reg2loc   = 1'b1;
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 1'b1;
                    pc_write  = zero;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for legv8_multicycle_control: an instruction-route model checked every cycle,
// plus literal state traces and counter/flag expectations.
module tb_legv8_multicycle_control;

    localparam int MEM_TIMEOUT = 16;
    localparam int COUNT_WIDTH = 64;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    logic clock = 1'b0;
    logic reset;
    logic [10:0] opcode;
    logic zero, mem_ready;
    logic pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write;
    logic reg2loc, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
    logic [COUNT_WIDTH-1:0] instr_count;
    logic illegal, mem_fault;

    legv8_multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg2loc(reg2loc), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .instr_count(instr_count), .illegal(illegal), .mem_fault(mem_fault)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    wire [13:0] act_ctrl = {pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
                            reg2loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

    // Expected controls by phase; bit order pw ps iw iod mr mw r2l rw m2r a b[1:0] op[1:0].
    function automatic logic [13:0] exp_ctrl(input int st, input logic rdy, input logic z);
        case (st)
            0:  return {rdy, 1'b0, rdy, 11'b0_1_0_0_0_0_0_01_00};
            1:  return 14'b0_0_0_0_0_0_0_0_0_0_11_00;
            2:  return 14'b0_0_0_0_0_0_0_0_0_1_10_00;
            3:  return 14'b0_0_0_1_1_0_0_0_0_0_00_00;
            4:  return 14'b0_0_0_0_0_0_0_1_1_0_00_00;
            5:  return 14'b0_0_0_1_0_1_1_0_0_0_00_00;
            6:  return 14'b0_0_0_0_0_0_0_0_0_1_00_10;
            7:  return 14'b0_0_0_0_0_0_0_1_0_0_00_00;
            8:  return {z, 13'b1_0_0_0_0_1_0_0_1_00_01};
            9:  return 14'b1_1_0_0_0_0_0_0_0_0_00_00;
            default: return 14'b0;
        endcase
    endfunction

    // Model: each decoded instruction gets the list of phases it still has to visit.
    int m_state;
    int m_route[$];
    int m_wait;
    logic [63:0] m_count;
    logic m_illegal, m_fault;

    task automatic model_advance();
        m_wait = 0;
        if (m_state == 0) m_state = 1;
        else if (m_route.size() == 0) begin
            m_state = 0;
            m_count = m_count + 64'd1;
        end else m_state = m_route.pop_front();
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_route.delete(); m_wait = 0;
            m_count = 0; m_illegal = 0; m_fault = 0;
        end else if (m_state == 10) begin
        end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
            if (mem_ready) model_advance();
            else begin
                m_wait++;
                if (m_wait == MEM_TIMEOUT) begin m_state = 10; m_fault = 1; m_wait = 0; end
            end
        end else if (m_state == 1) begin
            if (opcode == OP_LDUR) m_route = '{2, 3, 4};
            else if (opcode == OP_STUR) m_route = '{2, 5};
            else if (opcode == OP_ADD || opcode == 11'b11001011000 ||
                     opcode == 11'b10001010000 || opcode == 11'b10101010000) m_route = '{6, 7};
            else if (opcode[10:3] == 8'hB4) m_route = '{8};
            else if (opcode[10:5] == 6'b000101) m_route = '{9};
            if (m_route.size() == 0) begin m_state = 10; m_illegal = 1; end
            else m_state = m_route.pop_front();
        end else model_advance();
    end

    always @(negedge clock) begin
        check("ctrl", {50'b0, act_ctrl}, {50'b0, reset ? 14'b0 : exp_ctrl(m_state, mem_ready, zero)});
        check("state", {60'b0, state}, 64'(m_state));
        check("instr_count", instr_count, m_count);
        check("flags", {62'b0, illegal, mem_fault}, {62'b0, m_illegal, m_fault});
    end

    int obs_state;
    logic obs_pw, obs_iw, obs_mr;

    task automatic tick();
        @(negedge clock); #1;
        obs_state = int'(state); obs_pw = pc_write; obs_iw = ir_write; obs_mr = mem_read;
        @(posedge clock); #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        int tr[$];
        int exp_tr[19] = '{0,1,6,7, 0,1,2,3,4, 0,1,2,5, 0,1,8, 0,1,9};
        logic [10:0] ops[5] = '{OP_ADD, OP_LDUR, OP_STUR, OP_CBZ, OP_B};
        int lens[5] = '{4, 5, 4, 3, 3};
        int pw_br, mr_n, iw_n, iw_pos, pw_n;

        reset = 1'b1; opcode = 11'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Park in MEM_READ, then reset between clock edges.
        opcode = OP_LDUR;
        repeat (3) tick();
        check("reach_mem_read", {60'b0, state}, 64'd3);
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_state", {60'b0, state}, 64'd0);
        check("async_reset_ctrl", {50'b0, act_ctrl}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0; mem_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            repeat (lens[i]) begin tick(); tr.push_back(obs_state); end
        end
        for (int i = 0; i < 19; i++) check($sformatf("trace[%0d]", i), 64'(tr[i]), 64'(exp_tr[i]));
        check("count_after_19", instr_count, 64'd5);

        // CBZ taken then untaken.
        opcode = OP_CBZ;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            pw_br = -1;
            repeat (3) begin tick(); if (obs_state == 8) pw_br = int'(obs_pw); end
            check($sformatf("cbz_pc_write[%0d]", k), 64'(pw_br), (k == 0) ? 64'd1 : 64'd0);
        end
        zero = 1'b0;
        check("count_after_cbz", instr_count, 64'd7);

        // Fetch waiting three cycles on memory.
        opcode = OP_B; mem_ready = 1'b0;
        mr_n = 0; iw_n = 0; iw_pos = -1; pw_n = 0;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            tick();
            mr_n += int'(obs_mr); pw_n += int'(obs_pw);
            if (obs_iw) begin iw_n++; iw_pos = c; end
        end
        check("fetch_mem_read_cycles", 64'(mr_n), 64'd4);
        check("fetch_ir_write_pulses", 64'(iw_n), 64'd1);
        check("fetch_ir_write_cycle", 64'(iw_pos), 64'd3);
        check("fetch_pc_write_pulses", 64'(pw_n), 64'd1);
        repeat (2) tick();
        check("count_after_b", instr_count, 64'd8);

        // MEM_READ timeout.
        opcode = OP_LDUR; mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        repeat (16) tick();
        check("timeout_state", {60'b0, state}, 64'd10);
        check("timeout_fault", {63'b0, mem_fault}, 64'd1);
        check("timeout_ctrl", {50'b0, act_ctrl}, 64'd0);
        repeat (2) tick();
        check("halt_sticky", {60'b0, state}, 64'd10);
        check("halt_count", instr_count, 64'd8);
        reset_pulse();
        check("post_reset_fault", {63'b0, mem_fault}, 64'd0);

        // Ready arriving on the last allowed cycle completes the load.
        mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        repeat (15) tick();
        mem_ready = 1'b1;
        tick();
        check("late_ready_state", {60'b0, state}, 64'd4);
        check("late_ready_fault", {63'b0, mem_fault}, 64'd0);
        tick();
        check("late_ready_count", instr_count, 64'd1);

        // Undecodable opcode.
        opcode = 11'h000;
        repeat (2) tick();
        check("illegal_state", {60'b0, state}, 64'd10);
        check("illegal_flag", {63'b0, illegal}, 64'd1);
        repeat (3) tick();
        check("illegal_sticky", {63'b0, illegal}, 64'd1);
        reset = 1'b1;
        #1;
        check("illegal_reset_state", {60'b0, state}, 64'd0);
        check("illegal_reset_flag", {63'b0, illegal}, 64'd0);
        check("illegal_reset_count", instr_count, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
